mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
Iterative HI/LO multiply/divide unit that consumes the two register-file read ports (rdout1 → rs_data, rdout2 → rt_data).
- Sits in the execute stage beside the ALU.
- Owns the architectural HI and LO registers; the MFHI/MFLO datapath reads them.
- One bit per cycle, shift-add multiply and restoring divide; busy/done handshake toward pipeline control.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request new operation; accepted only in IDLE
op  input  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV
rs_data  input  WIDTH  operand A / dividend (from reg file rdout1)
rt_data  input  WIDTH  operand B / divisor (from reg file rdout2)
hi_we  input  1  MTHI write strobe
lo_we  input  1  MTLO write strobe
hilo_wdata  input  WIDTH  MTHI/MTLO write data
busy  output  1  operation in progress
done  output  1  single-cycle completion pulse
hi  output  WIDTH  HI register (product high half / remainder)
lo  output  WIDTH  LO register (product low half / quotient)

Behaviour:
- Clocking/reset: single clock clk; reset rst is synchronous and active-high. On rst: state IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0. Reset mid-operation abandons the operation with no partial HI/LO update.
- States:
  - IDLE: start=1 latches op, rs_data and rt_data, clears the counter, then goes to MUL (op[0]=0) or DIV (op[0]=1). Later operand changes are ignored.
  - MUL/DIV: exactly WIDTH cycles, one iteration each; counter increments; the state exits after the iteration where the counter equals WIDTH-1.
  - DONE: one cycle; hi/lo written; done=1; then returns to IDLE.
- Latency: start accepted at edge N → busy=1 from N+1 through N+WIDTH (32 cycles) → done=1 and new hi/lo visible in cycle N+WIDTH+1 → IDLE at N+WIDTH+2.
- busy=1 only in MUL/DIV. done=1 only in DONE. busy and done are never both high.
- start while busy or in DONE: ignored. No queuing.
- hi_we/lo_we:
  - Honoured only in IDLE with start=0; register updated at that edge.
  - If start=1 in the same cycle, start wins and the write is dropped.
  - Ignored in MUL/DIV/DONE.
- Multiply: 2*WIDTH-bit unsigned product of operand magnitudes; hi = upper half, lo = lower half.
- Divide: restoring algorithm on magnitudes; lo = quotient, hi = remainder.
- Divide by zero: no exception; lo = all ones (32'hFFFFFFFF), hi = latched dividend unchanged. Still takes the full latency.
- All arithmetic is modulo 2^WIDTH per half; no overflow flags.

Optional Feature:
MULDIV_SIGNED_EN
- Defined:
  - op 10/11 are signed. Operands are converted to magnitudes at accept; their signs are latched.
  - In DONE: product negated (2*WIDTH-bit) if the signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
  - 32'h80000000 / 32'hFFFFFFFF gives lo=32'h80000000, hi=0.
  - Signed divide by zero follows the unsigned rule: lo=all ones, hi=original dividend.
- Undefined: op[1] is ignored. MULT behaves as MULTU and DIV as DIVU; no sign logic is synthesized. Latency is identical in both builds.

Test Plan:
1. MULTU rs=32'hFFFFFFFF rt=32'hFFFFFFFF, start at edge N → busy high for cycles N+1..N+32; done pulse in N+33 with hi=32'hFFFFFFFE, lo=32'h00000001.
2. DIVU rs=100 rt=7 → lo=14, hi=2; then DIVU rs=5 rt=0 → lo=32'hFFFFFFFF, hi=5, same 33-cycle latency.
3. With MULDIV_SIGNED_EN: MULT rs=32'hFFFFFFFD (-3) rt=7 → hi=32'hFFFFFFFF, lo=32'hFFFFFFEB. DIV rs=32'hFFFFFFF9 (-7) rt=2 → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. Without the macro: MULT rs=32'hFFFFFFFD rt=7 → hi=32'h00000006, lo=32'hFFFFFFEB.
4. rst asserted 10 cycles into DIVU 100/7 → next cycle busy=0, done=0, hi=0, lo=0; no done pulse follows. A fresh MULTU 6*7 then completes with lo=42, hi=0.
5. In IDLE: lo_we=1 with hilo_wdata=32'h8888 → lo=32'h8888 next cycle. During MUL: hi_we=1 and start=1 are both ignored, and hi/lo take only the product at done. start=1 together with hi_we=1 in IDLE → operation starts and hi is not written.
6. Back-to-back: start held high continuously with MULTU 3*4 → one operation per 34 cycles; each done pulse is exactly 1 cycle wide with lo=12.

Source files
------------

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Iterative HI/LO multiply/divide unit for the execute stage.
//            Shift-add multiply and restoring divide, one bit per cycle,
//            with a busy/done handshake and MTHI/MTLO write access.
// Options  : MULDIV_SIGNED_EN - when defined, op[1]=1 selects signed
//            MULT/DIV; when undefined, op[1] is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q;
    logic                 busy_q, done_q;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic [CW-1:0]        cnt_q;
    // Shared working register: {partial product | remainder, multiplier | quotient}
    logic [2*WIDTH-1:0]   prod_q;
    logic [WIDTH-1:0]     b_q;
    logic                 bzero_q;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_d;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_diff;
    logic [2*WIDTH-1:0]   div_d;
    logic [2*WIDTH-1:0]   mul_res;
    logic [WIDTH-1:0]     quo_res, rem_res;
    logic [WIDTH-1:0]     res_hi, res_lo;
    logic                 last_iter;

`ifdef MULDIV_SIGNED_EN
    logic                 sign_a, sign_b;
    logic                 neg_res_q, neg_rem_q;

    // Signed ops work on magnitudes; signs are restored when the result is written
    always_comb begin
        sign_a = op[1] & rs_data[WIDTH-1];
        sign_b = op[1] & rt_data[WIDTH-1];
        a_mag  = sign_a ? -rs_data : rs_data;
        b_mag  = sign_b ? -rt_data : rt_data;
    end
`else
    logic                 unused_op1;
    assign unused_op1 = op[1];
    assign a_mag      = rs_data;
    assign b_mag      = rt_data;
`endif

    // One multiply step (conditional add, shift right) and one restoring divide step
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, b_q} : '0);
        mul_d     = {mul_sum, prod_q[WIDTH-1:1]};
        div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_diff  = div_shift[WIDTH-1:0] - b_q;
        div_d     = {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                     prod_q[WIDTH-2:0], div_ge};
    end

    // Final HI/LO values taken from the last iteration's next state
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        mul_res = neg_res_q ? -mul_d : mul_d;
        quo_res = bzero_q ? '1 : (neg_res_q ? -div_d[WIDTH-1:0] : div_d[WIDTH-1:0]);
        // For a zero divisor the remainder is |dividend|, so this restores the dividend
        rem_res = neg_rem_q ? -div_d[2*WIDTH-1:WIDTH] : div_d[2*WIDTH-1:WIDTH];
`else
        mul_res = mul_d;
        quo_res = bzero_q ? '1 : div_d[WIDTH-1:0];
        rem_res = div_d[2*WIDTH-1:WIDTH];
`endif
        res_hi  = (state_q == S_DIV) ? rem_res : mul_res[2*WIDTH-1:WIDTH];
        res_lo  = (state_q == S_DIV) ? quo_res : mul_res[WIDTH-1:0];
    end

    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // Control FSM, iteration datapath and architectural HI/LO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            prod_q    <= '0;
            b_q       <= '0;
            bzero_q   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // start has priority over a same-cycle MTHI/MTLO
                        prod_q  <= {{WIDTH{1'b0}}, a_mag};
                        b_q     <= b_mag;
                        bzero_q <= (rt_data == '0);
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= op[0] ? S_DIV : S_MUL;
`ifdef MULDIV_SIGNED_EN
                        neg_res_q <= sign_a ^ sign_b;
                        neg_rem_q <= sign_a;
`endif
                    end else begin
                        if (hi_we) hi_q <= hilo_wdata;
                        if (lo_we) lo_q <= hilo_wdata;
                    end
                end
                S_MUL, S_DIV: begin
                    prod_q <= (state_q == S_DIV) ? div_d : mul_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (last_iter) begin
                        hi_q    <= res_hi;
                        lo_q    <= res_lo;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire
